// File: rtl/dmux_serial_router.sv
// Upstream driver for a 1:4 serial demux: serialises tagged words MSB-first while holding the select stable.
// Define DMUX_ROUTER_PARITY_EN to append an even-parity bit to every frame.
module dmux_serial_router #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        ch_i,
    output logic              ser_o,
    output logic [1:0]        sel_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [7:0]       GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef DMUX_ROUTER_PARITY_EN
        S_PAR   = 2'd2,
`endif
        S_GAP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        gap_q, gap_d;
    logic [1:0]        sel_q, sel_d;
    logic              done_q, done_d;
`ifdef DMUX_ROUTER_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
`ifdef DMUX_ROUTER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
`ifdef DMUX_ROUTER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Select is only loaded from IDLE, where SER is already 0, so lane changes never glitch.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
`ifdef DMUX_ROUTER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    state_d = S_SHIFT;
                    shift_d = data_i;
                    sel_d   = ch_i;
                    cnt_d   = '0;
`ifdef DMUX_ROUTER_PARITY_EN
                    par_d   = ^data_i;
`endif
                end
            end
            S_SHIFT: begin
                shift_d = shift_q << 1;
                if (cnt_q == LAST_BIT) begin
`ifdef DMUX_ROUTER_PARITY_EN
                    state_d = S_PAR;
`else
                    done_d = 1'b1;
                    gap_d  = '0;
                    if (HAS_GAP) state_d = S_GAP;
                    else         state_d = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef DMUX_ROUTER_PARITY_EN
            S_PAR: begin
                done_d = 1'b1;
                gap_d  = '0;
                if (HAS_GAP) state_d = S_GAP;
                else         state_d = S_IDLE;
            end
`endif
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else                   gap_d   = gap_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ser_o = 1'b0;
        if (state_q == S_SHIFT) ser_o = shift_q[DATA_W-1];
`ifdef DMUX_ROUTER_PARITY_EN
        if (state_q == S_PAR)   ser_o = par_q;
`endif
    end

    assign ready_o = (state_q == S_IDLE);
    assign busy_o  = (state_q != S_IDLE);
    assign sel_o   = sel_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_dmux_serial_router.sv
// Scoreboard bench for dmux_serial_router: a frame-schedule model predicts every output each cycle.
// Build with DMUX_ROUTER_PARITY_EN defined to exercise the parity variant.
module tb_dmux_serial_router;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned GAP    = 1;
`ifdef DMUX_ROUTER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic       ser;
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid = 1'b0;
    logic [DATA_W-1:0] data  = '0;
    logic [1:0]        ch    = '0;
    logic              ready, ser, busy, done;
    logic [1:0]        sel;

    int   vectors     = 0;
    int   miscompares = 0;
    int   acceptCnt   = 0;
    exp_t sched[$];
    exp_t expQ[$];
    logic [1:0] lastSel   = 2'd0;
    logic       lastReady = 1'b1;

    dmux_serial_router #(.DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
        .data_i(data), .ch_i(ch), .ser_o(ser), .sel_o(sel),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a handshake appends the whole frame's per-cycle outputs to a schedule.
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int   ones;
        if (!rst_n) begin
            sched.delete();
            expQ.delete();
            lastSel   = 2'd0;
            lastReady = 1'b1;
        end else begin
            if (lastReady && valid) begin
                acceptCnt++;
                lastSel = ch;
                ones = 0;
                for (int i = DATA_W - 1; i >= 0; i--) begin
                    e.ser = data[i]; e.sel = ch; e.busy = 1'b1; e.done = 1'b0; e.ready = 1'b0;
                    sched.push_back(e);
                    ones += int'(data[i]);
                end
                if (PAR_EN) begin
                    e.ser = logic'(ones % 2); e.sel = ch; e.busy = 1'b1; e.done = 1'b0; e.ready = 1'b0;
                    sched.push_back(e);
                end
                for (int g = 0; g < int'(GAP); g++) begin
                    e.ser = 1'b0; e.sel = ch; e.busy = 1'b1; e.done = (g == 0); e.ready = 1'b0;
                    sched.push_back(e);
                end
                e.ser = 1'b0; e.sel = ch; e.busy = 1'b0; e.done = (GAP == 0); e.ready = 1'b1;
                sched.push_back(e);
            end
            if (sched.size() > 0) begin
                e = sched.pop_front();
            end else begin
                e.ser = 1'b0; e.sel = lastSel; e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b1;
            end
            expQ.push_back(e);
            lastReady = e.ready;
        end
    end

    // Monitor: compares the DUT against the next scheduled expectation, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            e.ser = 1'b0; e.sel = 2'd0; e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b1;
        end else if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard: actual=empty required=entry at %0t", $time);
            e.ser = 1'b0; e.sel = lastSel; e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b1;
        end else begin
            e = expQ.pop_front();
        end
        checkOutput("ser",   8'(ser),   8'(e.ser));
        checkOutput("sel",   8'(sel),   8'(e.sel));
        checkOutput("busy",  8'(busy),  8'(e.busy));
        checkOutput("done",  8'(done),  8'(e.done));
        checkOutput("ready", 8'(ready), 8'(e.ready));
    end

    // Present one word and wait (bounded) until the model sees it accepted.
    task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic [1:0] c, input bit holdValid);
        int start;
        bit got;
        @(negedge clk);
        valid = 1'b1;
        data  = d;
        ch    = c;
        start = acceptCnt;
        got   = 1'b0;
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            @(posedge clk);
            #1;
            got = (acceptCnt != start);
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: actual=none required=handshake at %0t", $time);
        end
        if (!holdValid) valid = 1'b0;
    endtask

    task automatic applyReset(input int waitEdges);
        repeat (waitEdges) @(posedge clk);
        #2;
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ser",   8'(ser),   8'd0);
        checkOutput("rst_sel",   8'(sel),   8'd0);
        checkOutput("rst_busy",  8'(busy),  8'd0);
        checkOutput("rst_done",  8'(done),  8'd0);
        checkOutput("rst_ready", 8'(ready), 8'd1);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        valid = 1'b1;
        data  = 8'h5A;
        ch    = 2'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst_n = 1'b1;

        applyStimulus(8'hA5, 2'd2, 1'b0);
        repeat (12) @(negedge clk);

        applyStimulus(8'hFF, 2'd1, 1'b1);
        applyStimulus(8'h01, 2'd3, 1'b0);
        repeat (12) @(negedge clk);

        applyStimulus(8'hF0, 2'd2, 1'b0);
        applyReset(3);
        applyStimulus(8'hC3, 2'd1, 1'b0);
        repeat (12) @(negedge clk);

        applyStimulus(8'h81, 2'd3, 1'b0);
        applyStimulus(8'h3C, 2'd0, 1'b0);
        repeat (12) @(negedge clk);

        applyStimulus(8'h07, 2'd1, 1'b0);
        applyStimulus(8'h03, 2'd2, 1'b0);
        repeat (12) @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 3) != 0);
            data  = DATA_W'($urandom);
            ch    = 2'($urandom_range(0, 3));
            if (n == 200) applyReset(1 + $urandom_range(0, 6));
        end

        @(negedge clk);
        valid = 1'b0;
        repeat (30) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
